z_branch_ctrl: RTL and testbench

//  Sequencer for conditional branches on the multicore datapath. Tracks each core's Z-flag register

---
 rtl/z_branch_ctrl_pkg.sv | 22 ++
 rtl/z_branch_ctrl_if.sv | 29 ++
 rtl/z_branch_ctrl_fresh.sv | 28 ++
 rtl/z_branch_ctrl.sv | 137 +++++++++++++
 tb/tb_z_branch_ctrl.sv | 206 ++++++++++++++++++++
 5 files changed

// File: rtl/z_branch_ctrl_pkg.sv
// Shared types and codes for the conditional-branch sequencer.
package z_branch_ctrl_pkg;

  localparam int unsigned CNT_W = 8;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_WAIT  = 3'd1,
    ST_EVAL  = 3'd2,
    ST_ISSUE = 3'd3,
    ST_ABORT = 3'd4
  } state_t;

  localparam logic BR_JMPZ  = 1'b0;
  localparam logic BR_JMPNZ = 1'b1;

  // JMPZ takes on global Z=1, JMPNZ on global Z=0
  function automatic logic take_branch(input logic br_type, input logic z_all);
    return (br_type == BR_JMPNZ) ? ~z_all : z_all;
  endfunction

endpackage

// File: rtl/z_branch_ctrl_if.sv
// Decoder / zReg / PC side signals of the branch sequencer.
interface z_branch_ctrl_if #(
  parameter int unsigned CORE_CNT = 4,
  parameter int unsigned PC_WIDTH = 8
);
  logic [CORE_CNT-1:0] zWrEn;
  logic [CORE_CNT-1:0] zIn;
  logic [CORE_CNT-1:0] activeMask;
  logic                brReq;
  logic                brType;
  logic [PC_WIDTH-1:0] brTarget;
  logic                stall;
  logic                pcLoad;
  logic [PC_WIDTH-1:0] pcTarget;
  logic                brDone;
  logic                brTaken;
  logic                zAll;
  logic                timeoutErr;

  modport master (
    output zWrEn, zIn, activeMask, brReq, brType, brTarget,
    input  stall, pcLoad, pcTarget, brDone, brTaken, zAll, timeoutErr
  );

  modport slave (
    input  zWrEn, zIn, activeMask, brReq, brType, brTarget,
    output stall, pcLoad, pcTarget, brDone, brTaken, zAll, timeoutErr
  );
endinterface

// File: rtl/z_branch_ctrl_fresh.sv
// Per-core "Z freshly written" bits; a write in the same cycle as a clear keeps the bit set.
module z_fresh_tracker #(
  parameter int unsigned CORE_CNT = 4
) (
  input  logic                clk,
  input  logic                rstN,
  input  logic [CORE_CNT-1:0] i_set,
  input  logic                i_clr,
  input  logic [CORE_CNT-1:0] i_mask,
  output logic                o_all_fresh_c
);

  logic [CORE_CNT-1:0] r_fresh;
  logic [CORE_CNT-1:0] w_fresh_nxt;

  always_comb begin
    w_fresh_nxt = i_clr ? i_set : (r_fresh | i_set);
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) r_fresh <= '0;
    else       r_fresh <= w_fresh_nxt;
  end

  // Inactive cores count as fresh, so an empty mask is ready at once
  assign o_all_fresh_c = ((r_fresh & i_mask) == i_mask);

endmodule

// File: rtl/z_branch_ctrl.sv
// Branch sequencer: waits for fresh Z from every active core, forms global Z, issues PC load.
module z_branch_ctrl
  import z_branch_ctrl_pkg::*;
#(
  parameter int unsigned CORE_CNT = 4,
  parameter int unsigned PC_WIDTH = 8,
  parameter int unsigned TIMEOUT  = 255
) (
  input  logic                  clk,
  input  logic                  rstN,
  z_branch_ctrl_if.slave        bus
);

  state_t              r_state, w_state_nxt;
  logic [CNT_W-1:0]    r_cnt, w_cnt_nxt;
  logic [CNT_W-1:0]    w_cnt_inc;
  logic                r_type, w_type_nxt;
  logic [CORE_CNT-1:0] r_mask, w_mask_nxt;
  logic [PC_WIDTH-1:0] r_pc_target, w_pc_target_nxt;
  logic                r_taken, w_taken_nxt;
  logic                r_z_all, w_z_all_nxt;
  logic                r_stall, w_stall_nxt;
  logic                r_pc_load, w_pc_load_nxt;
  logic                r_br_done, w_br_done_nxt;
  logic                r_br_taken, w_br_taken_nxt;
  logic                r_timeout_err, w_timeout_err_nxt;
  logic                w_clr_fresh;
  logic                w_all_fresh;
  logic                w_z_eval;

  assign w_clr_fresh = (r_state == ST_ISSUE) || (r_state == ST_ABORT);
  assign w_z_eval    = &(bus.zIn | ~r_mask);
  assign w_cnt_inc   = r_cnt + CNT_W'(1);

  z_fresh_tracker #(.CORE_CNT(CORE_CNT)) u_fresh (
    .clk           (clk),
    .rstN          (rstN),
    .i_set         (bus.zWrEn),
    .i_clr         (w_clr_fresh),
    .i_mask        (r_mask),
    .o_all_fresh_c (w_all_fresh)
  );

  // Next-state and next-output logic
  always_comb begin
    w_state_nxt       = r_state;
    w_cnt_nxt         = r_cnt;
    w_type_nxt        = r_type;
    w_mask_nxt        = r_mask;
    w_pc_target_nxt   = r_pc_target;
    w_taken_nxt       = r_taken;
    w_z_all_nxt       = r_z_all;
    w_pc_load_nxt     = 1'b0;
    w_br_done_nxt     = 1'b0;
    w_br_taken_nxt    = r_br_taken;
    w_timeout_err_nxt = r_timeout_err;

    unique case (r_state)
      ST_IDLE: begin
        if (bus.brReq) begin
          w_state_nxt     = ST_WAIT;
          w_type_nxt      = bus.brType;
          w_mask_nxt      = bus.activeMask;
          w_pc_target_nxt = bus.brTarget;
          w_cnt_nxt       = '0;
        end
      end
      ST_WAIT: begin
        if (w_all_fresh) begin
          w_state_nxt = ST_EVAL;
        end else begin
          w_cnt_nxt = w_cnt_inc;
          if (w_cnt_inc == CNT_W'(TIMEOUT)) w_state_nxt = ST_ABORT;
        end
      end
      ST_EVAL: begin
        w_z_all_nxt = w_z_eval;
        w_taken_nxt = take_branch(r_type, w_z_eval);
        w_state_nxt = ST_ISSUE;
      end
      ST_ISSUE: begin
        w_pc_load_nxt  = r_taken;
        w_br_done_nxt  = 1'b1;
        w_br_taken_nxt = r_taken;
        w_state_nxt    = ST_IDLE;
      end
      ST_ABORT: begin
        w_br_done_nxt     = 1'b1;
        w_br_taken_nxt    = 1'b0;
        w_timeout_err_nxt = 1'b1;
        w_state_nxt       = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase

    w_stall_nxt = (w_state_nxt != ST_IDLE);
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      r_state       <= ST_IDLE;
      r_cnt         <= '0;
      r_type        <= BR_JMPZ;
      r_mask        <= '0;
      r_pc_target   <= '0;
      r_taken       <= 1'b0;
      r_z_all       <= 1'b1;
      r_stall       <= 1'b0;
      r_pc_load     <= 1'b0;
      r_br_done     <= 1'b0;
      r_br_taken    <= 1'b0;
      r_timeout_err <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_cnt         <= w_cnt_nxt;
      r_type        <= w_type_nxt;
      r_mask        <= w_mask_nxt;
      r_pc_target   <= w_pc_target_nxt;
      r_taken       <= w_taken_nxt;
      r_z_all       <= w_z_all_nxt;
      r_stall       <= w_stall_nxt;
      r_pc_load     <= w_pc_load_nxt;
      r_br_done     <= w_br_done_nxt;
      r_br_taken    <= w_br_taken_nxt;
      r_timeout_err <= w_timeout_err_nxt;
    end
  end

  assign bus.stall      = r_stall;
  assign bus.pcLoad     = r_pc_load;
  assign bus.pcTarget   = r_pc_target;
  assign bus.brDone     = r_br_done;
  assign bus.brTaken    = r_br_taken;
  assign bus.zAll       = r_z_all;
  assign bus.timeoutErr = r_timeout_err;

endmodule

// File: tb/tb_z_branch_ctrl.sv
// Directed bench for z_branch_ctrl: vector table plus reset, late-write and timeout sequences.
module tb_z_branch_ctrl;

  localparam int unsigned CORE_CNT = 4;
  localparam int unsigned PC_WIDTH = 8;
  localparam int unsigned TIMEOUT  = 10;
  localparam int          LIMIT    = 50;

  logic clk;
  logic rstN;
  int   n_checks;
  int   n_errors;

  z_branch_ctrl_if #(.CORE_CNT(CORE_CNT), .PC_WIDTH(PC_WIDTH)) bus ();

  z_branch_ctrl #(.CORE_CNT(CORE_CNT), .PC_WIDTH(PC_WIDTH), .TIMEOUT(TIMEOUT)) dut (
    .clk  (clk),
    .rstN (rstN),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] mask;
    logic [3:0] wr;
    logic [3:0] zin;
    logic       btype;
    logic [7:0] target;
    logic       exp_taken;
    logic       exp_zall;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic write_z(input logic [3:0] wr, input logic [3:0] zin);
    bus.zWrEn = wr;
    bus.zIn   = zin;
    step();
    bus.zWrEn = '0;
  endtask

  // Pulse brReq and count sampled cycles until brDone; stalls is how many of them had stall=1
  task automatic branch(input logic btype, input logic [7:0] tgt, input logic [3:0] mask,
                        output int cyc, output int stalls);
    bus.brReq      = 1'b1;
    bus.brType     = btype;
    bus.brTarget   = tgt;
    bus.activeMask = mask;
    cyc    = 0;
    stalls = 0;
    do begin
      step();
      bus.brReq = 1'b0;
      cyc++;
      if (bus.stall) stalls++;
    end while (!bus.brDone && cyc < LIMIT);
    if (cyc >= LIMIT) begin
      n_checks++;
      n_errors++;
      $display("FAIL brdone_wait: got no brDone expected one within %0d cycles", LIMIT);
    end
  endtask

  initial begin
    int cyc, stalls, extra;
    n_checks = 0;
    n_errors = 0;

    vecs[0] = '{4'b1111, 4'b1111, 4'b1111, 1'b0, 8'h3C, 1'b1, 1'b1};
    vecs[1] = '{4'b1111, 4'b1111, 4'b1101, 1'b1, 8'h5A, 1'b1, 1'b0};
    vecs[2] = '{4'b1111, 4'b1111, 4'b1101, 1'b0, 8'h77, 1'b0, 1'b0};
    vecs[3] = '{4'b0011, 4'b0011, 4'b0011, 1'b0, 8'h21, 1'b1, 1'b1};
    vecs[4] = '{4'b0000, 4'b0000, 4'b0000, 1'b0, 8'h11, 1'b1, 1'b1};
    vecs[5] = '{4'b0000, 4'b0000, 4'b0000, 1'b1, 8'h12, 1'b0, 1'b1};
    vecs[6] = '{4'b0101, 4'b0101, 4'b0101, 1'b1, 8'h44, 1'b0, 1'b1};
    vecs[7] = '{4'b1111, 4'b1111, 4'b0000, 1'b1, 8'h99, 1'b1, 1'b0};

    rstN           = 1'b0;
    bus.zWrEn      = '0;
    bus.zIn        = '0;
    bus.activeMask = '0;
    bus.brReq      = 1'b0;
    bus.brType     = 1'b0;
    bus.brTarget   = '0;
    repeat (2) step();
    rstN = 1'b1;
    step();

    check("rst_stall",    32'(bus.stall),      32'd0);
    check("rst_pcload",   32'(bus.pcLoad),     32'd0);
    check("rst_brdone",   32'(bus.brDone),     32'd0);
    check("rst_brtaken",  32'(bus.brTaken),    32'd0);
    check("rst_pctarget", 32'(bus.pcTarget),   32'd0);
    check("rst_zall",     32'(bus.zAll),       32'd1);
    check("rst_timeout",  32'(bus.timeoutErr), 32'd0);

    for (int i = 0; i < 8; i++) begin
      write_z(vecs[i].wr, vecs[i].zin);
      branch(vecs[i].btype, vecs[i].target, vecs[i].mask, cyc, stalls);
      check($sformatf("v%0d_latency", i),  32'(cyc),          32'd4);
      check($sformatf("v%0d_taken", i),    32'(bus.brTaken),  32'(vecs[i].exp_taken));
      check($sformatf("v%0d_pcload", i),   32'(bus.pcLoad),   32'(vecs[i].exp_taken));
      check($sformatf("v%0d_zall", i),     32'(bus.zAll),     32'(vecs[i].exp_zall));
      check($sformatf("v%0d_pctarget", i), 32'(bus.pcTarget), 32'(vecs[i].target));
      check($sformatf("v%0d_stall", i),    32'(bus.stall),    32'd0);
      step();
      check($sformatf("v%0d_pcload_pulse", i), 32'(bus.pcLoad),   32'd0);
      check($sformatf("v%0d_target_hold", i),  32'(bus.pcTarget), 32'(vecs[i].target));
    end

    // Late writes: cores 0,1 now, cores 2,3 five cycles on; zIn changes before EVAL
    write_z(4'b0011, 4'b0000);
    bus.brReq      = 1'b1;
    bus.brType     = 1'b0;
    bus.brTarget   = 8'h66;
    bus.activeMask = 4'b1111;
    step();
    bus.brReq = 1'b0;
    for (int k = 0; k < 5; k++) begin
      if (k == 2) begin
        bus.brReq    = 1'b1;
        bus.brTarget = 8'hEE;
      end
      step();
      bus.brReq = 1'b0;
      check($sformatf("late_stall%0d", k), 32'(bus.stall),  32'd1);
      check($sformatf("late_done%0d", k),  32'(bus.brDone), 32'd0);
    end
    bus.zIn   = 4'b1111;
    bus.zWrEn = 4'b1100;
    cyc = 0;
    do begin
      step();
      bus.zWrEn = '0;
      cyc++;
    end while (!bus.brDone && cyc < LIMIT);
    check("late_cycles",   32'(cyc),          32'd4);
    check("late_taken",    32'(bus.brTaken),  32'd1);
    check("late_zall",     32'(bus.zAll),     32'd1);
    check("late_pctarget", 32'(bus.pcTarget), 32'h66);
    extra = 0;
    for (int k = 0; k < 8; k++) begin
      step();
      if (bus.brDone) extra++;
    end
    check("late_single_done", 32'(extra), 32'd0);

    // Reset in the middle of WAIT
    bus.brReq      = 1'b1;
    bus.brType     = 1'b1;
    bus.brTarget   = 8'hA5;
    bus.activeMask = 4'b1111;
    step();
    bus.brReq = 1'b0;
    step();
    check("mid_stall_before", 32'(bus.stall), 32'd1);
    rstN = 1'b0;
    #1;
    check("mid_stall_async", 32'(bus.stall),  32'd0);
    check("mid_done_async",  32'(bus.brDone), 32'd0);
    step();
    rstN = 1'b1;
    extra = 0;
    for (int k = 0; k < 14; k++) begin
      step();
      if (bus.brDone || bus.stall || bus.pcLoad) extra++;
    end
    check("mid_quiet",    32'(extra),          32'd0);
    check("mid_timeout",  32'(bus.timeoutErr), 32'd0);
    check("mid_pctarget", 32'(bus.pcTarget),   32'd0);

    // Timeout: core 3 never writes
    write_z(4'b0111, 4'b1111);
    branch(1'b0, 8'h5C, 4'b1111, cyc, stalls);
    check("to_cycles",  32'(cyc),            32'd12);
    check("to_taken",   32'(bus.brTaken),    32'd0);
    check("to_pcload",  32'(bus.pcLoad),     32'd0);
    check("to_err",     32'(bus.timeoutErr), 32'd1);
    check("to_stall",   32'(bus.stall),      32'd0);
    step();
    write_z(4'b1111, 4'b1111);
    branch(1'b0, 8'h3C, 4'b1111, cyc, stalls);
    check("after_to_taken",  32'(bus.brTaken),    32'd1);
    check("after_to_pcload", 32'(bus.pcLoad),     32'd1);
    check("after_to_sticky", 32'(bus.timeoutErr), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
